// File: rtl/stream_fifo_fallthrough_pkg.sv
// Shared sizing helper for the stream FIFOs.
// Pointer width is clog2 of the depth, never less than one bit.
package stream_fifo_fallthrough_pkg;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/stream_fifo_fallthrough.sv
// Valid/ready FIFO with first-word fall-through: an empty FIFO forwards w_data_i to r_data_o combinationally.
// Latency 0 when empty, else strict FIFO order; w_ready_o depends only on occupancy (no r_ready_i path).
// Optional STREAM_FIFO_FALLTHROUGH_LEVEL_EN adds level_o (registered occupancy) and occupancy assertions.
module stream_fifo_fallthrough
    import stream_fifo_fallthrough_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  w_ready_o,
    input  logic                  w_valid_i,
    input  logic [DATA_WIDTH-1:0] w_data_i,
    output logic                  r_valid_o,
    input  logic                  r_ready_i,
    output logic [DATA_WIDTH-1:0] r_data_o
`ifdef STREAM_FIFO_FALLTHROUGH_LEVEL_EN
    ,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] level_o
`endif
);

    localparam int PTR_W = ptr_width(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic empty, full, w_fire, r_fire, bypass, store, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH_C);
    assign w_ready_o = !full;
    assign r_valid_o = !empty | w_valid_i;
    assign r_data_o  = empty ? w_data_i : mem_q[rd_ptr_q];

    assign w_fire = w_valid_i & w_ready_o;
    assign r_fire = r_valid_o & r_ready_i;
    // A beat consumed in the same cycle it arrives at an empty FIFO never touches storage.
    assign bypass = empty & w_fire & r_ready_i;
    assign store  = w_fire & !bypass;
    assign pop    = r_fire & !empty;

    always_comb begin
        wr_ptr_d = store ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop   ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({store, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (store) begin
            mem_q[wr_ptr_q] <= w_data_i;
        end
    end

`ifdef STREAM_FIFO_FALLTHROUGH_LEVEL_EN
    assign level_o = count_q;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(store && full));
            assert (!(pop && empty));
            assert (count_q <= DEPTH_C);
        end
    end
`endif

endmodule

// File: tb/tb_stream_fifo_fallthrough.sv
// Directed bench for stream_fifo_fallthrough: a DEPTH=4 instance for bypass/fill/drain/reset and a DEPTH=3 instance for wrap.
// Inputs are driven 1 time unit after the rising edge and outputs sampled 1 unit later.
module tb_stream_fifo_fallthrough;

    logic        clk;
    logic        rst_n;

    logic        w_ready, w_valid, r_valid, r_ready;
    logic [31:0] w_data, r_data;

    logic        w_ready3, w_valid3, r_valid3, r_ready3;
    logic [31:0] w_data3, r_data3;

`ifdef STREAM_FIFO_FALLTHROUGH_LEVEL_EN
    logic [2:0]  level;
    logic [1:0]  level3;
`endif

    int n_cmp;
    int n_err;

    stream_fifo_fallthrough #(.DATA_WIDTH(32), .FIFO_DEPTH(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .w_ready_o (w_ready),
        .w_valid_i (w_valid),
        .w_data_i  (w_data),
        .r_valid_o (r_valid),
        .r_ready_i (r_ready),
        .r_data_o  (r_data)
`ifdef STREAM_FIFO_FALLTHROUGH_LEVEL_EN
        ,
        .level_o   (level)
`endif
    );

    stream_fifo_fallthrough #(.DATA_WIDTH(32), .FIFO_DEPTH(3)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .w_ready_o (w_ready3),
        .w_valid_i (w_valid3),
        .w_data_i  (w_data3),
        .r_valid_o (r_valid3),
        .r_ready_i (r_ready3),
        .r_data_o  (r_data3)
`ifdef STREAM_FIFO_FALLTHROUGH_LEVEL_EN
        ,
        .level_o   (level3)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        w_valid = 1'b0; w_data = '0; r_ready = 1'b0;
        w_valid3 = 1'b0; w_data3 = '0; r_ready3 = 1'b0;
        #3;
        n_cmp++;
        if (w_ready !== 1'b1) begin n_err++; $display("FAIL reset_w_ready got=%b exp=1", w_ready); end
        n_cmp++;
        if (r_valid !== 1'b0) begin n_err++; $display("FAIL reset_r_valid got=%b exp=0", r_valid); end
        n_cmp++;
        if (w_ready3 !== 1'b1 || r_valid3 !== 1'b0) begin
            n_err++; $display("FAIL reset_dut3 got w_ready=%b r_valid=%b exp 1/0", w_ready3, r_valid3);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_bypass();
        w_valid = 1'b1; w_data = 32'hA5A5_0001; r_ready = 1'b1;
        #1;
        n_cmp++;
        if (r_valid !== 1'b1 || r_data !== 32'hA5A5_0001) begin
            n_err++; $display("FAIL bypass_data got v=%b d=%h exp v=1 d=a5a50001", r_valid, r_data);
        end
        next_cycle();
        w_valid = 1'b0;
        #1;
        n_cmp++;
        if (r_valid !== 1'b0 || w_ready !== 1'b1) begin
            n_err++; $display("FAIL bypass_no_store got r_valid=%b w_ready=%b exp 0/1", r_valid, w_ready);
        end
        next_cycle();
    endtask

    task automatic test_fill();
        r_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_valid = 1'b1; w_data = 32'h10 + 32'(i);
            #1;
            n_cmp++;
            if (w_ready !== 1'b1 || r_valid !== 1'b1 || r_data !== 32'h10) begin
                n_err++; $display("FAIL fill_beat%0d got w_ready=%b r_valid=%b r_data=%h exp 1/1/10", i, w_ready, r_valid, r_data);
            end
            next_cycle();
        end
        w_data = 32'h14;
        #1;
        n_cmp++;
        if (w_ready !== 1'b0 || r_data !== 32'h10) begin
            n_err++; $display("FAIL fill_full got w_ready=%b r_data=%h exp 0/10", w_ready, r_data);
        end
        next_cycle();
        #1;
        n_cmp++;
        if (w_ready !== 1'b0 || r_data !== 32'h10) begin
            n_err++; $display("FAIL fill_held got w_ready=%b r_data=%h exp 0/10", w_ready, r_data);
        end
        next_cycle();
    endtask

    task automatic test_full_drain();
        logic [31:0] exp_seq [5];
        exp_seq = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h14};
        r_ready = 1'b1; w_valid = 1'b1; w_data = 32'h14;
        #1;
        n_cmp++;
        if (w_ready !== 1'b0 || r_data !== exp_seq[0]) begin
            n_err++; $display("FAIL drain_c1 got w_ready=%b r_data=%h exp 0/%h", w_ready, r_data, exp_seq[0]);
        end
        next_cycle();
        #1;
        n_cmp++;
        if (w_ready !== 1'b1 || r_data !== exp_seq[1]) begin
            n_err++; $display("FAIL drain_c2 got w_ready=%b r_data=%h exp 1/%h", w_ready, r_data, exp_seq[1]);
        end
        next_cycle();
        w_valid = 1'b0;
        for (int k = 2; k < 5; k++) begin
            #1;
            n_cmp++;
            if (r_valid !== 1'b1 || r_data !== exp_seq[k]) begin
                n_err++; $display("FAIL drain_order%0d got v=%b d=%h exp v=1 d=%h", k, r_valid, r_data, exp_seq[k]);
            end
            next_cycle();
        end
        #1;
        n_cmp++;
        if (r_valid !== 1'b0 || w_ready !== 1'b1) begin
            n_err++; $display("FAIL drain_empty got r_valid=%b w_ready=%b exp 0/1", r_valid, w_ready);
        end
        r_ready = 1'b0;
        next_cycle();
    endtask

    task automatic test_wrap();
        logic [15:0] pat;
        int next_in;
        int exp_out;
        int cyc;
        pat = 16'b1011_0010_1110_0101;
        next_in = 0; exp_out = 0; cyc = 0;
        while (cyc < 200 && exp_out < 10) begin
            w_valid3 = (next_in < 10);
            w_data3  = 32'(next_in);
            r_ready3 = pat[cyc % 16];
            #1;
            if (r_valid3 && r_ready3) begin
                n_cmp++;
                if (r_data3 !== 32'(exp_out)) begin
                    n_err++; $display("FAIL wrap_order got=%0d exp=%0d", r_data3, exp_out);
                end
                exp_out++;
            end
            if (w_valid3 && w_ready3) next_in++;
            next_cycle();
            cyc++;
        end
        w_valid3 = 1'b0; r_ready3 = 1'b1;
        n_cmp++;
        if (exp_out != 10) begin
            n_err++; $display("FAIL wrap_count got=%0d exp=10 (cycle budget)", exp_out);
        end
        #1;
        n_cmp++;
        if (r_valid3 !== 1'b0) begin
            n_err++; $display("FAIL wrap_no_dup got r_valid=%b exp 0", r_valid3);
        end
        r_ready3 = 1'b0;
        next_cycle();
    endtask

    task automatic test_async_reset();
        r_ready = 1'b0;
        w_valid = 1'b1; w_data = 32'h21;
        next_cycle();
        w_data = 32'h22;
        next_cycle();
        w_valid = 1'b0;
        #1;
        n_cmp++;
        if (r_valid !== 1'b1 || r_data !== 32'h21) begin
            n_err++; $display("FAIL arst_pre got v=%b d=%h exp v=1 d=21", r_valid, r_data);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (r_valid !== 1'b0 || w_ready !== 1'b1) begin
            n_err++; $display("FAIL arst_immediate got r_valid=%b w_ready=%b exp 0/1", r_valid, w_ready);
        end
        next_cycle();
        rst_n = 1'b1;
        #1;
        w_valid = 1'b1; w_data = 32'h44; r_ready = 1'b1;
        #1;
        n_cmp++;
        if (r_valid !== 1'b1 || r_data !== 32'h44) begin
            n_err++; $display("FAIL arst_bypass got v=%b d=%h exp v=1 d=44", r_valid, r_data);
        end
        next_cycle();
        w_valid = 1'b0;
        #1;
        n_cmp++;
        if (r_valid !== 1'b0) begin
            n_err++; $display("FAIL arst_after_bypass got r_valid=%b exp 0", r_valid);
        end
        r_ready = 1'b0;
        next_cycle();
    endtask

`ifdef STREAM_FIFO_FALLTHROUGH_LEVEL_EN
    task automatic test_level();
        logic [31:0] q [$];
        logic        wf, byp;
        for (int c = 0; c < 1000; c++) begin
            w_valid = 1'($urandom_range(0, 1));
            w_data  = $urandom;
            r_ready = 1'($urandom_range(0, 1));
            #1;
            n_cmp++;
            if (level !== 3'(q.size())) begin
                n_err++; $display("FAIL level_track c=%0d got=%0d exp=%0d", c, level, q.size());
            end
            n_cmp++;
            if (w_ready !== (q.size() < 4)) begin
                n_err++; $display("FAIL level_w_ready c=%0d got=%b exp=%b", c, w_ready, (q.size() < 4));
            end
            if (r_ready && (q.size() > 0 || w_valid)) begin
                n_cmp++;
                if (r_data !== ((q.size() > 0) ? q[0] : w_data)) begin
                    n_err++; $display("FAIL level_data c=%0d got=%h", c, r_data);
                end
            end
            wf  = w_valid && (q.size() < 4);
            byp = (q.size() == 0) && wf && r_ready;
            if (r_ready && q.size() > 0) void'(q.pop_front());
            if (wf && !byp) q.push_back(w_data);
            next_cycle();
        end
        w_valid = 1'b0; r_ready = 1'b0;
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_bypass();
        test_fill();
        test_full_drain();
        test_wrap();
        test_async_reset();
`ifdef STREAM_FIFO_FALLTHROUGH_LEVEL_EN
        test_level();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
